alu_pipe: RTL and testbench

Parametrised, handshaked successor of the CPU execute-stage ALU. It takes two WIDTH-bit operands and a 4-bit opcode over a valid/ready interface and returns a registered result with zero/carry/negative/overflow flags. Single-cycle operations have one-cycle latency and full throughput. MUL is iterative shift-add over WIDTH cycles, controlled by a small FSM. The block sits between decode/regfile read and writeback.

---
 rtl/alu_pipe.sv | 183 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Execute-stage ALU with valid/ready handshake on both sides.
// Single-cycle ops issue every cycle; MUL runs an iterative shift-add over WIDTH cycles.
module alu_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sr1,
  input  logic [WIDTH-1:0] sr2,
  input  logic [3:0]       os,
  input  logic [SHW-1:0]   shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             zeroflag,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_ROL = 4'd8, OP_ROR = 4'd9, OP_MUL = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     count_q;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             zero_q, zero_d, carry_q, carry_d, neg_q, neg_d;
  logic             ovf_q, ovf_d, err_q, err_d;

  logic             out_free, accept, is_mul;
  logic [WIDTH-1:0] alu_rd;
  logic             alu_c, alu_v, alu_e;
  logic [WIDTH:0]   sum_ext, diff_ext, shl_ext, shr_ext;
  logic signed [WIDTH:0] sra_ext;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == S_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (os == OP_MUL);

  // Shifts are computed one bit wider so the last bit shifted out lands in the spare bit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    alu_rd   = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_e    = 1'b0;
    sum_ext  = {1'b0, sr1} + {1'b0, sr2};
    diff_ext = {1'b0, sr1} - {1'b0, sr2};
    shl_ext  = {1'b0, sr1} << shift;
    shr_ext  = {sr1, 1'b0} >> shift;
    sra_ext  = $signed({sr1, 1'b0}) >>> shift;
    case (os)
      OP_ADD: begin
        alu_rd = sum_ext[WIDTH-1:0];
        alu_c  = sum_ext[WIDTH];
        alu_v  = (sr1[WIDTH-1] == sr2[WIDTH-1]) && (alu_rd[WIDTH-1] != sr1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_rd = diff_ext[WIDTH-1:0];
        alu_c  = diff_ext[WIDTH];
        alu_v  = (sr1[WIDTH-1] != sr2[WIDTH-1]) && (alu_rd[WIDTH-1] != sr1[WIDTH-1]);
      end
      OP_AND: alu_rd = sr1 & sr2;
      OP_OR:  alu_rd = sr1 | sr2;
      OP_XOR: alu_rd = sr1 ^ sr2;
      OP_SLL: begin
        alu_rd = shl_ext[WIDTH-1:0];
        alu_c  = shl_ext[WIDTH];
      end
      OP_SRL: begin
        alu_rd = shr_ext[WIDTH:1];
        alu_c  = shr_ext[0];
      end
      OP_SRA: begin
        alu_rd = sra_ext[WIDTH:1];
        alu_c  = sra_ext[0];
      end
      OP_ROL: alu_rd = (sr1 << shift) | (sr1 >> (WIDTH - int'(shift)));
      OP_ROR: alu_rd = (sr1 >> shift) | (sr1 << (WIDTH - int'(shift)));
      OP_MUL: alu_rd = '0;
      default: alu_e = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && is_mul) state_d = S_MUL;
      S_MUL:  if (count_q == '0)    state_d = S_DONE;
      S_DONE: if (out_free)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accept and MUL write-back are exclusive since they need IDLE and DONE respectively.
  always_comb begin
    out_valid_d = out_valid_q;
    rd_d        = rd_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      rd_d        = alu_rd;
      zero_d      = (alu_rd == '0);
      carry_d     = alu_c;
      neg_d       = alu_rd[WIDTH-1];
      ovf_d       = alu_v;
      err_d       = alu_e;
    end else if (state_q == S_DONE && out_free) begin
      out_valid_d = 1'b1;
      rd_d        = acc_q[WIDTH-1:0];
      zero_d      = (acc_q[WIDTH-1:0] == '0);
      carry_d     = |acc_q[2*WIDTH-1:WIDTH];
      neg_d       = acc_q[WIDTH-1];
      ovf_d       = 1'b0;
      err_d       = 1'b0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rd_q        <= rd_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      if (state_q == S_IDLE && accept && is_mul) begin
        mcand_q  <= {{WIDTH{1'b0}}, sr1};
        mplier_q <= sr2;
        acc_q    <= '0;
        count_q  <= SHW'(WIDTH - 1);
      end else if (state_q == S_MUL) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q - 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign zeroflag  = zero_q;
  assign carry     = carry_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed literal cases plus random traffic checked against
// an arithmetic reference model through an in-order expectation queue.
module tb_alu_pipe;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sr1 = '0, sr2 = '0;
  logic [3:0]    os = '0;
  logic [4:0]    shift = '0;
  logic          in_ready, out_valid, zeroflag, carry, neg, ovf, err;
  logic [W-1:0]  rd;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sr1(sr1), .sr2(sr2), .os(os), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
    .zeroflag(zeroflag), .carry(carry), .neg(neg), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {rd, zeroflag, carry, neg, ovf, err}
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op, input logic [4:0] s);
    logic [31:0] r;
    logic        c, v, e;
    logic [63:0] p;
    int          n;
    n = int'(s);
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      4'd0: begin
        p = 64'(a) + 64'(b);
        r = p[31:0];
        c = p[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = a << n; c = (n != 0) ? a[32-n] : 1'b0; end
      4'd6: begin r = a >> n; c = (n != 0) ? a[n-1] : 1'b0; end
      4'd7: begin r = 32'($signed(a) >>> n); c = (n != 0) ? a[n-1] : 1'b0; end
      4'd8: r = (n != 0) ? ((a << n) | (a >> (32 - n))) : a;
      4'd9: r = (n != 0) ? ((a >> n) | (a << (32 - n))) : a;
      4'd10: begin
        p = 64'(a) * 64'(b);
        r = p[31:0];
        c = |p[63:32];
      end
      default: e = 1'b1;
    endcase
    return {r, (r == 32'h0), c, r[31], v, e};
  endfunction

  // Compare process: the head of the queue must sit on the output every valid cycle.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got rd=%h with no result outstanding", rd);
        end else begin
          check("model", {rd, zeroflag, carry, neg, ovf, err}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(sr1, sr2, os, shift));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [4:0] s);
    bit ok;
    ok = 1'b0;
    sr1 = a; sr2 = b; os = op; shift = s; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    step();
    in_valid = 1'b0;
    sr1 = $urandom;
    sr2 = $urandom;
  endtask

  task automatic expect_result(input string name, input logic [31:0] r, input logic z,
                               input logic c, input logic n, input logic v, input logic e);
    for (int i = 0; i < 100 && !out_valid; i++) step();
    check(name, {out_valid, rd, zeroflag, carry, neg, ovf, err}, {1'b1, r, z, c, n, v, e});
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  cnt;
    int  sent;
    bit  fired;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {out_valid, rd, zeroflag, carry, neg, ovf, err},
          {1'b0, 32'h0, 1'b1, 4'b0000});
    step();
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);
    step();

    send(32'd9, 32'd1, 4'd0, 5'd0); expect_result("add_9_1", 32'd10, 0, 0, 0, 0, 0);
    send(32'd9, 32'd1, 4'd1, 5'd0); expect_result("sub_9_1", 32'd8,  0, 0, 0, 0, 0);
    send(32'd9, 32'd1, 4'd2, 5'd0); expect_result("and_9_1", 32'd1,  0, 0, 0, 0, 0);
    send(32'd9, 32'd1, 4'd3, 5'd0); expect_result("or_9_1",  32'd9,  0, 0, 0, 0, 0);
    send(32'd9, 32'd1, 4'd4, 5'd0); expect_result("xor_9_1", 32'd8,  0, 0, 0, 0, 0);
    send(32'd1, 32'd9, 4'd1, 5'd0); expect_result("sub_borrow", 32'hFFFF_FFF8, 0, 1, 1, 0, 0);
    send(32'h7FFF_FFFF, 32'd1, 4'd0, 5'd0); expect_result("add_ovf", 32'h8000_0000, 0, 0, 1, 1, 0);
    send(32'h8000_0000, 32'd0, 4'd7, 5'd4); expect_result("sra_4", 32'hF800_0000, 0, 0, 1, 0, 0);
    send(32'h8000_0001, 32'd0, 4'd5, 5'd1); expect_result("sll_1", 32'd2, 0, 1, 0, 0, 0);
    send(32'h0000_0001, 32'd0, 4'd9, 5'd1); expect_result("ror_1", 32'h8000_0000, 0, 0, 1, 0, 0);
    send(32'd77, 32'd5, 4'd12, 5'd3);       expect_result("reserved_12", 32'h0, 1, 0, 0, 0, 1);

    // MUL busy window and latency, counted in cycles after the accept edge.
    send(32'h0001_0000, 32'h0001_0000, 4'd10, 5'd0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
    end
    check("mul_busy_cycles", 64'(cnt), 64'd33);
    check("mul_wrap", {out_valid, rd, zeroflag, carry, neg, ovf, err},
          {1'b1, 32'h0, 1'b1, 1'b1, 3'b000});
    step();
    send(32'd6, 32'd7, 4'd10, 5'd0); expect_result("mul_6x7", 32'd42, 0, 0, 0, 0, 0);
    step();

    // Backpressure: hold one result, then retire it and accept on the same edge.
    out_ready = 1'b0;
    send(32'd5, 32'd3, 4'd0, 5'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {in_ready, out_valid, rd}, {1'b0, 1'b1, 32'd8});
    end
    step();
    sr1 = 32'd20; sr2 = 32'd22; os = 4'd0; shift = 5'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_with_out_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_same_edge", {out_valid, rd}, {1'b1, 32'd42});
    step();

    // Reset five cycles into a MUL.
    send(32'd123, 32'd456, 4'd10, 5'd0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_abort", {out_valid, rd, zeroflag}, {1'b0, 32'h0, 1'b1});
    step();
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_abort", {in_ready, out_valid}, {1'b1, 1'b0});
    repeat (40) step();

    // Random traffic with random output backpressure.
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 300; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        sr1 = rand_val();
        sr2 = rand_val();
        os = 4'($urandom_range(0, 15));
        shift = 5'($urandom);
        in_valid = 1'b1;
      end
      @(negedge clk);
      fired = in_valid && in_ready;
      step();
      if (fired) begin
        in_valid = 1'b0;
        sent++;
        sr1 = $urandom;
        sr2 = $urandom;
      end
    end
    check("random_ops_sent", 64'(sent), 64'd300);

    out_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
